// File: rtl/wshb_ram_responder.sv
// wshb_ram_responder: Wishbone B4 pipelined slave backed by a DEPTH-word RAM with fixed ack latency.
// Define WSHB_STALL_INJECT_EN to raise stall_o for one cycle in every STALL_PERIOD cycles.
module wshb_ram_responder #(
   parameter int DEPTH        = 1024,
   parameter int ADDR_W       = 32,
   parameter int LATENCY      = 2,
   parameter int STALL_PERIOD = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cyc_i,
   input  logic              stb_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] adr_i,
   input  logic [3:0]        sel_i,
   input  logic [31:0]       dat_i,
   output logic [31:0]       dat_o,
   output logic              ack_o,
   output logic              err_o,
   output logic              stall_o,
   output logic [15:0]       rd_count
);

   localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int IDX_W  = ADDR_W - 2;

   logic [31:0]       mem [DEPTH];
   logic [IDX_W-1:0]  idx;
   logic [RAM_AW-1:0] ram_idx;
   logic              oor;
   logic              acc;
   logic              unused_adr;

   assign idx        = adr_i[ADDR_W-1:2];
   assign ram_idx    = idx[RAM_AW-1:0];
   assign oor        = (idx >= IDX_W'(DEPTH));
   assign acc        = cyc_i & stb_i & ~stall_o;
   assign unused_adr = ^adr_i[1:0];

   // Byte-lane write; out-of-range writes are dropped here and only answered with err_o.
   always_ff @(posedge clk) begin
      if (acc && we_i && !oor) begin
         for (int k = 0; k < 4; k++) begin
            if (sel_i[k]) mem[ram_idx][8*k +: 8] <= dat_i[8*k +: 8];
         end
      end
   end

   // Response pipeline: in_* is what every stage loads at the next edge.
   logic [LATENCY-1:0] st_v, st_e, st_w;
   logic [LATENCY-1:0] in_v, in_e, in_w;
   logic [31:0]        st_d [LATENCY];
   logic [31:0]        in_d [LATENCY];

   always_comb begin
      in_v    = '0;
      in_e    = '0;
      in_w    = '0;
      in_v[0] = acc;
      in_e[0] = oor;
      in_w[0] = we_i;
      in_d[0] = (we_i || oor) ? 32'd0 : mem[ram_idx];
      for (int k = 1; k < LATENCY; k++) begin
         in_v[k] = st_v[k-1];
         in_e[k] = st_e[k-1];
         in_w[k] = st_w[k-1];
         in_d[k] = st_d[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_v <= '0;
         st_e <= '0;
         st_w <= '0;
         for (int k = 0; k < LATENCY; k++) st_d[k] <= '0;
      end else begin
         st_v <= cyc_i ? in_v : '0;
         st_e <= in_e;
         st_w <= in_w;
         for (int k = 0; k < LATENCY; k++) st_d[k] <= in_d[k];
      end
   end

   assign ack_o = cyc_i & st_v[LATENCY-1] & ~st_e[LATENCY-1];
   assign err_o = cyc_i & st_v[LATENCY-1] &  st_e[LATENCY-1];

   // dat_o is loaded together with the last stage so it is valid in the ack cycle itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dat_o    <= '0;
         rd_count <= '0;
      end else begin
         if (cyc_i && in_v[LATENCY-1] && !in_w[LATENCY-1]) dat_o <= in_d[LATENCY-1];
         if (ack_o && !st_w[LATENCY-1]) rd_count <= rd_count + 16'd1;
      end
   end

`ifdef WSHB_STALL_INJECT_EN
   localparam int SC_W = $clog2(STALL_PERIOD);
   logic [SC_W-1:0] stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    stall_cnt <= '0;
      else if (stall_cnt == SC_W'(STALL_PERIOD - 1)) stall_cnt <= '0;
      else                                           stall_cnt <= stall_cnt + SC_W'(1);
   end

   assign stall_o = (stall_cnt == SC_W'(STALL_PERIOD - 1));
`else
   assign stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_wshb_ram_responder.sv
// tb_wshb_ram_responder: randomized bench for wshb_ram_responder against a queue-based response model.
// Compile with WSHB_STALL_INJECT_EN defined to cover the stall-injection build.
module tb_wshb_ram_responder;

   localparam int DEPTH = 1024;
   localparam int LAT   = 2;
   localparam int SP    = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
   logic [31:0] adr_i = '0;
   logic [3:0]  sel_i = '0;
   logic [31:0] dat_i = '0;
   logic [31:0] dat_o;
   logic        ack_o, err_o, stall_o;
   logic [15:0] rd_count;

   wshb_ram_responder #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(LAT), .STALL_PERIOD(SP)) dut (
      .clk(clk), .rst_n(rst_n), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .adr_i(adr_i),
      .sel_i(sel_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o),
      .stall_o(stall_o), .rd_count(rd_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // Reference model: word array plus a queue of responses due at acceptance cycle + LAT.
   typedef struct {
      int          due;
      bit          err;
      bit          rd;
      bit          known;
      logic [31:0] data;
   } resp_t;

   logic [31:0] mdl_mem   [DEPTH];
   bit          mdl_known [DEPTH];
   resp_t       pend[$];
   int          cyc_n = 0;
   int          since_rst = 0;
   int          n_ack = 0, n_err = 0, mdl_rd = 0;
   int          ack_run = 0, max_run = 0;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) since_rst <= 0;
      else        since_rst <= since_rst + 1;
   end

   resp_t       r;
   bit          e_ack, e_err, e_stall;
   int unsigned ix;

   always @(negedge clk) begin
      if (!rst_n) begin
         pend.delete();
         mdl_rd  = 0;
         ack_run = 0;
      end else begin
         e_ack = 1'b0;
         e_err = 1'b0;
         r     = '{due: 0, err: 1'b0, rd: 1'b0, known: 1'b0, data: '0};
         if (!cyc_i) pend.delete();
         else if (pend.size() > 0 && pend[0].due == cyc_n) begin
            r     = pend.pop_front();
            e_ack = !r.err;
            e_err = r.err;
         end
         checks++;
         if (ack_o !== e_ack || err_o !== e_err)
            $display("FAIL termination cycle=%0d got ack=%b err=%b want ack=%b err=%b", cyc_n, ack_o, err_o, e_ack, e_err);
         else passed++;
         if (r.rd && (e_err || r.known)) begin
            checks++;
            if (dat_o !== (e_err ? 32'd0 : r.data))
               $display("FAIL read_data cycle=%0d got %h want %h", cyc_n, dat_o, e_err ? 32'd0 : r.data);
            else passed++;
         end
`ifdef WSHB_STALL_INJECT_EN
         e_stall = (since_rst % SP) == SP - 1;
`else
         e_stall = 1'b0;
`endif
         checks++;
         if (stall_o !== e_stall) $display("FAIL stall cycle=%0d got %b want %b", cyc_n, stall_o, e_stall);
         else passed++;
         if (e_ack) begin
            n_ack++;
            ack_run++;
            if (ack_run > max_run) max_run = ack_run;
            if (r.rd) mdl_rd++;
         end else ack_run = 0;
         if (e_err) n_err++;
         if (cyc_i && stb_i && !stall_o) begin
            ix = adr_i[31:2];
            r  = '{due: cyc_n + LAT, err: ix >= DEPTH, rd: !we_i, known: 1'b0, data: '0};
            if (!r.err && !we_i) begin
               r.known = mdl_known[ix];
               r.data  = mdl_mem[ix];
            end
            if (!r.err && we_i) begin
               for (int k = 0; k < 4; k++)
                  if (sel_i[k]) mdl_mem[ix][8*k +: 8] = dat_i[8*k +: 8];
               if (sel_i == 4'hF) mdl_known[ix] = 1'b1;
            end
            pend.push_back(r);
         end
      end
   end

   task automatic issue(input bit we, input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
      bit done = 1'b0;
      cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; sel_i = sel; dat_i = dat;
      for (int t = 0; t < 32 && !done; t++) begin
         @(negedge clk);
         if (stall_o === 1'b0) done = 1'b1;
         @(posedge clk); #1;
      end
      if (!done) begin
         checks++;
         $display("FAIL issue_timeout adr=%h stall_o=%b want 0 within 32 cycles", adr, stall_o);
      end
   endtask

   task automatic drain();
      int t = 0;
      stb_i = 1'b0;
      while (pend.size() > 0 && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      @(posedge clk); #1;
      checks++;
      if (pend.size() != 0) $display("FAIL drain_timeout got %0d responses outstanding want 0", pend.size());
      else passed++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (ack_o !== 1'b0)     $display("FAIL reset_ack got %b want 0", ack_o);         else passed++;
      checks++; if (err_o !== 1'b0)     $display("FAIL reset_err got %b want 0", err_o);         else passed++;
      checks++; if (dat_o !== 32'd0)    $display("FAIL reset_dat got %h want 0", dat_o);         else passed++;
      checks++; if (stall_o !== 1'b0)   $display("FAIL reset_stall got %b want 0", stall_o);     else passed++;
      checks++; if (rd_count !== 16'd0) $display("FAIL reset_rd_count got %0d want 0", rd_count); else passed++;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      int a0 = n_ack;
      issue(1'b1, 32'h10, 4'hF, 32'hCAFEBABE);
      issue(1'b0, 32'h10, 4'h0, 32'h0);
      drain();
      checks++; if (n_ack - a0 != 2)        $display("FAIL single_acks got %0d want 2", n_ack - a0);   else passed++;
      checks++; if (dat_o !== 32'hCAFEBABE) $display("FAIL single_dat got %h want cafebabe", dat_o);   else passed++;
      checks++; if (rd_count !== 16'd1)     $display("FAIL single_rd_count got %0d want 1", rd_count); else passed++;
   endtask

   task automatic test_partial();
      issue(1'b1, 32'h40, 4'hF, 32'hAAAAAAAA);
      issue(1'b1, 32'h40, 4'b0101, 32'h11223344);
      issue(1'b1, 32'h40, 4'h0, 32'hFFFFFFFF);
      issue(1'b0, 32'h40, 4'h0, 32'h0);
      drain();
      checks++; if (dat_o !== 32'hAA22AA44) $display("FAIL partial_dat got %h want aa22aa44", dat_o);   else passed++;
      checks++; if (rd_count !== 16'd2)     $display("FAIL partial_rd_count got %0d want 2", rd_count); else passed++;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) issue(1'b1, 32'(i * 4), 4'hF, 32'(i));
      drain();
      max_run = 0;
      for (int i = 0; i < 8; i++) issue(1'b0, 32'(i * 4), 4'h0, 32'h0);
      drain();
      checks++; if (rd_count !== 16'd10) $display("FAIL b2b_rd_count got %0d want 10", rd_count); else passed++;
      checks++; if (dat_o !== 32'd7)     $display("FAIL b2b_last_dat got %h want 7", dat_o);      else passed++;
`ifndef WSHB_STALL_INJECT_EN
      checks++; if (max_run != 8) $display("FAIL b2b_ack_run got %0d want 8", max_run); else passed++;
`endif
   endtask

   task automatic test_error();
      int e0;
      issue(1'b1, 32'h0, 4'hF, 32'h12345678);
      drain();
      e0 = n_err;
      issue(1'b0, 32'(DEPTH * 4), 4'h0, 32'h0);
      issue(1'b1, 32'(DEPTH * 4), 4'hF, 32'hDEADBEEF);
      drain();
      checks++; if (n_err - e0 != 2)     $display("FAIL err_count got %0d want 2", n_err - e0);       else passed++;
      checks++; if (dat_o !== 32'd0)     $display("FAIL err_read_dat got %h want 0", dat_o);         else passed++;
      checks++; if (rd_count !== 16'd10) $display("FAIL err_rd_count got %0d want 10", rd_count);    else passed++;
      issue(1'b0, 32'h0, 4'h0, 32'h0);
      drain();
      checks++; if (dat_o !== 32'h12345678) $display("FAIL err_word0_intact got %h want 12345678", dat_o); else passed++;
   endtask

   task automatic test_cyc_drop();
      int a0 = n_ack;
      issue(1'b0, 32'h4, 4'h0, 32'h0);
      issue(1'b0, 32'h8, 4'h0, 32'h0);
      issue(1'b0, 32'hC, 4'h0, 32'h0);
      cyc_i = 1'b0; stb_i = 1'b0;
      repeat (4) @(posedge clk);
      #1;
`ifndef WSHB_STALL_INJECT_EN
      checks++; if (n_ack - a0 != 1) $display("FAIL drop_acks got %0d want 1", n_ack - a0); else passed++;
`endif
      a0 = n_ack;
      cyc_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (n_ack != a0) $display("FAIL drop_stale got %0d acks want 0", n_ack - a0); else passed++;
      issue(1'b0, 32'h14, 4'h0, 32'h0);
      drain();
      checks++; if (n_ack - a0 != 1) $display("FAIL drop_new_ack got %0d want 1", n_ack - a0); else passed++;
      checks++; if (dat_o !== 32'd5) $display("FAIL drop_new_dat got %h want 5", dat_o);       else passed++;
   endtask

   task automatic test_stall_stream();
      int a0 = n_ack;
      for (int i = 0; i < 20; i++) issue(1'b0, 32'((i % 8) * 4), 4'h0, 32'h0);
      drain();
      checks++; if (n_ack - a0 != 20) $display("FAIL stream_acks got %0d want 20", n_ack - a0); else passed++;
      checks++; if (dat_o !== 32'd3)  $display("FAIL stream_last_dat got %h want 3", dat_o);    else passed++;
   endtask

   task automatic test_random();
      int unsigned rix;
      for (int i = 16; i < 80; i++) issue(1'b1, 32'(i * 4), 4'hF, $urandom);
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 15))
            0: begin cyc_i = 1'b0; stb_i = 1'b0; @(posedge clk); #1; end
            1, 2: begin cyc_i = 1'b1; stb_i = 1'b0; @(posedge clk); #1; end
            default: begin
               if ($urandom_range(0, 7) == 0) begin
                  case ($urandom_range(0, 2))
                     0:       rix = DEPTH;
                     1:       rix = DEPTH + 5;
                     default: rix = 32'h3FFF_FFFF;
                  endcase
               end else rix = $urandom_range(16, 79);
               issue(1'($urandom_range(0, 1)), {rix[29:0], 2'($urandom_range(0, 3))}, 4'($urandom_range(0, 15)), $urandom);
            end
         endcase
      end
      cyc_i = 1'b1;
      drain();
      checks++; if (rd_count !== 16'(mdl_rd)) $display("FAIL random_rd_count got %0d want %0d", rd_count, mdl_rd); else passed++;
   endtask

   task automatic test_async_reset();
      for (int i = 1; i <= 4; i++) issue(1'b0, 32'(i * 4), 4'h0, 32'h0);
      #1 rst_n = 1'b0;
      #1;
      checks++; if (ack_o !== 1'b0)     $display("FAIL areset_ack got %b want 0", ack_o);          else passed++;
      checks++; if (err_o !== 1'b0)     $display("FAIL areset_err got %b want 0", err_o);          else passed++;
      checks++; if (dat_o !== 32'd0)    $display("FAIL areset_dat got %h want 0", dat_o);          else passed++;
      checks++; if (stall_o !== 1'b0)   $display("FAIL areset_stall got %b want 0", stall_o);      else passed++;
      checks++; if (rd_count !== 16'd0) $display("FAIL areset_rd_count got %0d want 0", rd_count); else passed++;
      cyc_i = 1'b0; stb_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      issue(1'b0, 32'h0, 4'h0, 32'h0);
      drain();
      checks++; if (dat_o !== 32'h12345678) $display("FAIL areset_ram_kept got %h want 12345678", dat_o); else passed++;
      checks++; if (rd_count !== 16'd1)     $display("FAIL areset_rd_count_after got %0d want 1", rd_count); else passed++;
   endtask

   initial begin
      test_reset();
      @(posedge clk); #1;
      test_single();
      test_partial();
      test_back_to_back();
      test_error();
      test_cyc_drop();
      test_stall_stream();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/wshb_ram_responder.md
Name: wshb_ram_responder

Overview:
- Wishbone B4 pipelined responder (slave) backed by an on-chip word RAM.
- Serves the frame-buffer read master and the test write master in the SoC so that video-path masters can run without SDRAM.
- Fixed, parameterised ack latency; in-order responses; error response for out-of-range addresses.
- Optional periodic stall injection to exercise master flow control.

Parameters:
- DEPTH, 1024, number of 32-bit words in RAM.
- ADDR_W, 32, width of the byte address bus.
- LATENCY, 2, cycles from request acceptance to ack/err, legal range 1..8.
- STALL_PERIOD, 16, stall-injection period in cycles, minimum 2; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cyc_i  in  1  bus cycle in progress
- stb_i  in  1  request strobe
- we_i  in  1  1=write, 0=read
- adr_i  in  ADDR_W  byte address; bits [1:0] ignored
- sel_i  in  4  byte enables for writes
- dat_i  in  32  write data
- dat_o  out  32  read data, valid when ack_o=1
- ack_o  out  1  normal termination
- err_o  out  1  error termination (out-of-range address)
- stall_o  out  1  request not accepted this cycle
- rd_count  out  16  number of completed read acks, wraps at 65535 to 0

Behaviour:
- Reset (rst_n=0, asynchronous) clears:
  - all pipeline-valid bits
  - ack_o=0, err_o=0, dat_o=0, stall_o=0
  - rd_count=0 and the stall counter
  - RAM contents are not cleared.
- Acceptance: a request is accepted in cycle n when cyc_i & stb_i & ~stall_o. At most one request is accepted per cycle.
- Word index is adr_i[ADDR_W-1:2].
  - Index >= DEPTH marks the request as an error.
  - An error write does not modify the RAM.
  - An error read returns dat_o=0.
- Write: byte lanes with sel_i[k]=1 are committed at the clock edge ending cycle n. sel_i=0 is legal: the write is acked and nothing is modified.
- Read: RAM is sampled on acceptance. A read accepted in cycle n+1 sees a write accepted in cycle n.
- Response pipeline:
  - A LATENCY-deep shift register carries {valid, err, we, data}.
  - A request accepted in cycle n produces exactly one ack_o or err_o pulse in cycle n+LATENCY.
  - Responses come back in acceptance order.
  - Back-to-back requests give back-to-back acks: full throughput, 1 request per cycle.
- dat_o holds its last value when ack_o=0. It is updated only on a read response.
- ack_o and err_o are never high together.
- rd_count increments in every cycle where ack_o=1 on a read response. Error reads do not count.
- cyc_i dropped mid-operation:
  - ack_o and err_o are gated with cyc_i, so there are no terminations while cyc_i=0.
  - All in-flight stages are invalidated at the next edge.
  - Writes already accepted remain committed.
  - The discarded responses are never delivered later.
- stb_i while cyc_i=0 is ignored.
- Requests held during stall_o=1 are accepted in the first cycle stall_o=0, with no loss or duplication.

Optional Feature:
- Macro: WSHB_STALL_INJECT_EN.
- When defined:
  - A free-running counter cycles 0..STALL_PERIOD-1.
  - stall_o=1 while counter==STALL_PERIOD-1, one cycle per period.
  - The counter runs regardless of bus activity and resets to 0.
- When undefined: stall_o is constant 0 and the counter logic is absent.

Test Plan:
- Reset then single write adr=0x10, dat=0xCAFEBABE, sel=0xF, followed by a read of adr=0x10 -> with LATENCY=2, write ack in cycle n+2; read ack 2 cycles after its acceptance with dat_o=0xCAFEBABE; rd_count=1.
- Partial write sel=0b0101, dat=0x11223344 over a word holding 0xAAAAAAAA, then read -> dat_o=0xAA22AA44.
- 8 back-to-back reads of adr 0x0..0x1C after filling with value=index -> 8 consecutive ack cycles starting 2 cycles after the first acceptance, data 0..7 in order; rd_count=8.
- Read and write at word index DEPTH (adr=DEPTH*4) -> err_o pulse at latency, ack_o=0; a later read of index 0 is unchanged; rd_count unchanged.
- cyc_i dropped 1 cycle after 3 reads are issued -> no ack/err while cyc_i=0. On re-asserting cyc_i, no stale acks; a new read acks normally at LATENCY.
- With WSHB_STALL_INJECT_EN and STALL_PERIOD=4, stream 20 reads -> stall_o high every 4th cycle; exactly 20 acks with correct in-order data.
- Asynchronous reset asserted mid-stream -> ack_o, err_o, dat_o, stall_o and rd_count go to 0 immediately. After release, RAM still holds the prior data.
